// File: rtl/shift_sticky_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shift_sticky_arbiter
// Function : Round-robin shared barrel shifter with sticky-OR/AND of lost bits
// Revision : 1.0 - initial release
// ============================================================================
module shift_sticky_arbiter #(
   parameter int NUM_REQ         = 4,
   parameter int WIDTH           = 16,
   parameter int SHIFT_VAL_WIDTH = $clog2(WIDTH + 1),
   parameter int ID_WIDTH        = $clog2(NUM_REQ)
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_REQ-1:0]                   i_reqValid,
   output logic [NUM_REQ-1:0]                   o_reqReady,
   input  logic [NUM_REQ*WIDTH-1:0]             i_reqIn,
   input  logic [NUM_REQ*SHIFT_VAL_WIDTH-1:0]   i_reqShift,
   input  logic [NUM_REQ-1:0]                   i_reqDir,
   output logic                                 o_respValid,
   input  logic                                 i_respReady,
   output logic [WIDTH-1:0]                     o_respOut,
   output logic                                 o_respSticky,
   output logic                                 o_respStickyAnd,
   output logic [ID_WIDTH-1:0]                  o_respId
);

   localparam logic [WIDTH-1:0] c_ONES = '1;

   logic [ID_WIDTH-1:0]        r_rr_ptr;
   logic                       r_resp_valid;
   logic [WIDTH-1:0]           r_resp_out;
   logic                       r_resp_sticky;
   logic                       r_resp_sticky_and;
   logic [ID_WIDTH-1:0]        r_resp_id;

   logic [ID_WIDTH-1:0]        w_scan_idx;
   logic [ID_WIDTH-1:0]        w_gnt_idx;
   logic [ID_WIDTH-1:0]        w_ptr_next;
   logic                       w_any;
   logic                       w_can_accept;
   logic                       w_accept;
   logic [WIDTH-1:0]           w_in;
   logic [SHIFT_VAL_WIDTH-1:0] w_shift;
   logic                       w_dir;
   logic [WIDTH-1:0]           w_out;
   logic [WIDTH-1:0]           w_mask;
   logic                       w_sticky;
   logic                       w_sticky_and;

   // Scan from the highest offset down so the lowest offset from r_rr_ptr wins.
   always_comb begin
      w_any      = 1'b0;
      w_gnt_idx  = '0;
      w_scan_idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_scan_idx = ID_WIDTH'((int'(r_rr_ptr) + k) % NUM_REQ);
         if (i_reqValid[w_scan_idx]) begin
            w_any     = 1'b1;
            w_gnt_idx = w_scan_idx;
         end
      end
   end

   assign w_ptr_next   = (w_gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
   assign w_can_accept = ~r_resp_valid | i_respReady;
   assign w_accept     = w_any & w_can_accept & ~rst;

   always_comb begin
      o_reqReady = '0;
      if (w_accept) begin
         o_reqReady[w_gnt_idx] = 1'b1;
      end
   end

   always_comb begin
      w_in    = '0;
      w_shift = '0;
      w_dir   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_gnt_idx == ID_WIDTH'(i)) begin
            w_in    = i_reqIn[i*WIDTH +: WIDTH];
            w_shift = i_reqShift[i*SHIFT_VAL_WIDTH +: SHIFT_VAL_WIDTH];
            w_dir   = i_reqDir[i];
         end
      end
   end

   // w_mask marks the operand bits pushed out; shifts >= WIDTH saturate to all ones.
   always_comb begin
      if (w_dir) begin
         w_out  = w_in >> w_shift;
         w_mask = ~(c_ONES << w_shift);
      end else begin
         w_out  = w_in << w_shift;
         w_mask = ~(c_ONES >> w_shift);
      end
   end

   assign w_sticky     = |(w_in & w_mask);
   assign w_sticky_and = &(w_in | ~w_mask);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr_ptr          <= '0;
         r_resp_valid      <= 1'b0;
         r_resp_out        <= '0;
         r_resp_sticky     <= 1'b0;
         r_resp_sticky_and <= 1'b0;
         r_resp_id         <= '0;
      end else if (w_accept) begin
         r_rr_ptr          <= w_ptr_next;
         r_resp_valid      <= 1'b1;
         r_resp_out        <= w_out;
         r_resp_sticky     <= w_sticky;
         r_resp_sticky_and <= w_sticky_and;
         r_resp_id         <= w_gnt_idx;
      end else if (i_respReady) begin
         r_resp_valid      <= 1'b0;
      end
   end

   assign o_respValid     = r_resp_valid;
   assign o_respOut       = r_resp_out;
   assign o_respSticky    = r_resp_sticky;
   assign o_respStickyAnd = r_resp_sticky_and;
   assign o_respId        = r_resp_id;

endmodule
`default_nettype wire

// File: tb/tb_shift_sticky_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_sticky_arbiter
// Function : Directed and randomized checks of shift_sticky_arbiter
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_sticky_arbiter;

   localparam int N  = 4;
   localparam int W  = 16;
   localparam int SW = 5;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  reqValid;
   logic [N-1:0]  reqReady;
   logic [N-1:0]  reqDir;
   logic [N*W-1:0]  reqIn;
   logic [N*SW-1:0] reqShift;
   logic          respValid;
   logic          respReady;
   logic [W-1:0]  respOut;
   logic          respSticky;
   logic          respStickyAnd;
   logic [IW-1:0] respId;

   int checks = 0;
   int errors = 0;

   shift_sticky_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
      .clk             (clk),
      .rst             (rst),
      .i_reqValid      (reqValid),
      .o_reqReady      (reqReady),
      .i_reqIn         (reqIn),
      .i_reqShift      (reqShift),
      .i_reqDir        (reqDir),
      .o_respValid     (respValid),
      .i_respReady     (respReady),
      .o_respOut       (respOut),
      .o_respSticky    (respSticky),
      .o_respStickyAnd (respStickyAnd),
      .o_respId        (respId)
   );

   always #5 clk = ~clk;

   // Reference state: contents of the output slot and the next-priority requester
   bit         m_valid, n_valid;
   logic [W-1:0] m_out, n_out;
   bit         m_st, n_st, m_sa, n_sa;
   int         m_id, n_id, m_ptr, n_ptr;
   bit         have_next = 1'b0;
   bit         checking  = 1'b0;
   logic [N-1:0] last_ready = '0;
   int         g;
   bit         can;
   logic [N-1:0] er;
   logic [W-1:0] f_out;
   bit         f_st, f_sa;
   int         exp2[4] = '{2, 3, 0, 2};
   logic [W-1:0] held_out;
   logic [IW-1:0] held_id;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Bit-by-bit definition: each output bit copies its source bit if it exists,
   // and the lost bits are the ones whose destination falls off the word.
   function automatic void ref_shift(input logic [W-1:0] x, input int s, input bit dir,
                                     output logic [W-1:0] o, output bit st, output bit sa);
      int cnt;
      int ones;
      int src;
      bit gone;
      cnt  = 0;
      ones = 0;
      o    = '0;
      for (int b = 0; b < W; b++) begin
         src = dir ? b + s : b - s;
         if (src >= 0 && src < W) o[b] = x[src];
         gone = dir ? (b < s) : (b >= W - s);
         if (gone) begin
            cnt++;
            if (x[b]) ones++;
         end
      end
      st = (ones > 0);
      sa = (ones == cnt);
   endfunction

   task automatic model_reset();
      m_valid   = 1'b0;
      m_out     = '0;
      m_st      = 1'b0;
      m_sa      = 1'b0;
      m_id      = 0;
      m_ptr     = 0;
      have_next = 1'b0;
      last_ready = '0;
   endtask

   always @(negedge clk) begin
      if (!rst && checking) begin
         g = -1;
         for (int k = 0; k < N; k++) begin
            if (g < 0 && reqValid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
         end
         can = !m_valid || respReady;
         er  = '0;
         if (g >= 0 && can) er[g] = 1'b1;
         chk("reqReady",      32'(reqReady),      32'(er));
         chk("respValid",     32'(respValid),     32'(m_valid));
         chk("respOut",       32'(respOut),       32'(m_out));
         chk("respSticky",    32'(respSticky),    32'(m_st));
         chk("respStickyAnd", 32'(respStickyAnd), 32'(m_sa));
         chk("respId",        32'(respId),        32'(m_id));
         n_valid = m_valid; n_out = m_out; n_st = m_st; n_sa = m_sa;
         n_id = m_id; n_ptr = m_ptr;
         if (g >= 0 && can) begin
            ref_shift(reqIn[g*W +: W], int'(reqShift[g*SW +: SW]), reqDir[g], f_out, f_st, f_sa);
            n_valid = 1'b1; n_out = f_out; n_st = f_st; n_sa = f_sa;
            n_id = g; n_ptr = (g + 1) % N;
         end else if (respReady) begin
            n_valid = 1'b0;
         end
         have_next  = 1'b1;
         last_ready = reqReady;
      end
   end

   always @(posedge clk) begin
      if (!rst && have_next) begin
         m_valid = n_valid; m_out = n_out; m_st = n_st; m_sa = n_sa;
         m_id = n_id; m_ptr = n_ptr;
         have_next = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [W-1:0] x, input int s, input bit d);
      reqIn[i*W +: W]     = x;
      reqShift[i*SW +: SW] = SW'(s);
      reqDir[i]           = d;
   endtask

   // One request through an otherwise idle arbiter, checked against literals.
   task automatic single(input string nm, input int i, input logic [W-1:0] x, input int s,
                         input bit d, input logic [W-1:0] eo, input bit es, input bit ea);
      set_req(i, x, s, d);
      reqValid    = '0;
      reqValid[i] = 1'b1;
      step();
      reqValid = '0;
      chk({nm, "_out"}, 32'(respOut), 32'(eo));
      chk({nm, "_st"},  32'(respSticky), 32'(es));
      chk({nm, "_sa"},  32'(respStickyAnd), 32'(ea));
      chk({nm, "_id"},  32'(respId), 32'(i));
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("rst_async_valid", 32'(respValid), 32'd0);
      chk("rst_ready_zero",  32'(reqReady),  32'd0);
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      reqValid  = '1;
      reqIn     = '0;
      reqShift  = '0;
      reqDir    = '0;
      respReady = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid",  32'(respValid),     32'd0);
      chk("reset_out",    32'(respOut),       32'd0);
      chk("reset_st",     32'(respSticky),    32'd0);
      chk("reset_sa",     32'(respStickyAnd), 32'd0);
      chk("reset_id",     32'(respId),        32'd0);
      chk("reset_ready",  32'(reqReady),      32'd0);
      reqValid  = '0;
      rst       = 1'b0;
      checking  = 1'b1;
      respReady = 1'b1;

      single("t_single", 2, 16'h8001, 1,  1'b1, 16'h4000, 1'b1, 1'b1);
      single("t_left_a", 0, 16'hF00F, 4,  1'b0, 16'h00F0, 1'b1, 1'b1);
      single("t_left_b", 1, 16'h0F0F, 4,  1'b0, 16'hF0F0, 1'b0, 1'b0);
      single("t_s0",     3, 16'h1234, 0,  1'b0, 16'h1234, 1'b0, 1'b1);
      single("t_s16",    0, 16'hFFFF, 16, 1'b1, 16'h0000, 1'b1, 1'b1);
      single("t_s31",    2, 16'h0000, 31, 1'b0, 16'h0000, 1'b0, 1'b0);

      // Round robin from a freshly reset pointer
      do_reset();
      for (int i = 0; i < N; i++) set_req(i, W'(16'h1111 * (i + 1)), i + 1, i[0]);
      reqValid = '1;
      for (int j = 0; j < 6; j++) begin
         step();
         chk("rr_id", 32'(respId), 32'(j % N));
      end
      reqValid = 4'b1101;
      for (int j = 0; j < 4; j++) begin
         step();
         chk("rr_drop_id", 32'(respId), 32'(exp2[j]));
      end

      // Back-pressure: slot holds, no grants
      reqValid  = 4'b0111;
      respReady = 1'b0;
      step();
      held_out = respOut;
      held_id  = respId;
      for (int j = 0; j < 5; j++) begin
         chk("bp_valid", 32'(respValid), 32'd1);
         chk("bp_ready", 32'(reqReady),  32'd0);
         chk("bp_hold",  32'({held_id, held_out}), 32'({respId, respOut}));
         step();
      end
      respReady = 1'b1;
      #1;
      chk("bp_release", 32'(reqReady != '0), 32'd1);
      repeat (3) step();

      // Reset while the slot is full and requests wait
      respReady = 1'b0;
      reqValid  = '1;
      step();
      do_reset();
      reqValid  = 4'b1110;
      respReady = 1'b1;
      step();
      chk("rst_first_id", 32'(respId), 32'd1);
      reqValid = '0;

      // Randomized traffic honouring the hold-until-ready obligation
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (reqValid[i] && !last_ready[i]) begin
               if ($urandom_range(0, 15) == 0) reqValid[i] = 1'b0;
            end else begin
               reqValid[i] = ($urandom_range(0, 2) != 0);
               set_req(i, W'($urandom),
                       ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) != 0 ? 16 : 0)
                                                   : int'($urandom_range(0, 31)),
                       $urandom_range(0, 1) != 0);
            end
         end
         respReady = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 499) == 0) do_reset();
         else step();
      end

      checking = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
